// File: rtl/pulse_ctrl_pkg.sv
// Shared types and helpers for the pulse controller result path.
// Source indices, arbiter state encoding and a small bit-count helper.
package pulse_ctrl_pkg;

    localparam int SRC_DDS      = 0;
    localparam int SRC_SPI      = 1;
    localparam int SRC_LOOPBACK = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic int unsigned count_ones(input logic [31:0] vec);
        int unsigned total;
        total = 32'd0;
        for (int i = 0; i < 32; i++) begin
            total = total + {31'd0, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/result_src_queue.sv
// Single-source circular queue feeding the result write arbiter.
// A push into a full queue is still taken when the same edge pops it.
module result_src_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    assign pop_ok_s  = pop && (count_r != '0);
    assign push_ok_s = push && (!full || pop_ok_s);
    assign empty     = (count_r == '0);
    assign full      = (count_r == (PTR_W + 1)'(DEPTH));
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap on their own width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Round-robin arbiter sharing the result-FIFO write port between per-source
// queues, with a minimum write gap, full backpressure and drop accounting.
module result_write_arbiter
    import pulse_ctrl_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int GAP        = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_SRC*DATA_WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]              src_wr_req,
    input  logic                          rFIFO_full,
    input  logic                          clear_overflow,
    output logic [DATA_WIDTH-1:0]         rFIFO_data,
    output logic                          rFIFO_WrReq,
    output logic [N_SRC-1:0]              src_overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          pending,
    output logic [$clog2(N_SRC)-1:0]      last_grant
);

    localparam int LG_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int SUM_W = CNT_WIDTH + LG_W + 1;

    logic [N_SRC-1:0]      empty_s;
    logic [N_SRC-1:0]      full_s;
    logic [N_SRC-1:0]      pop_s;
    logic [N_SRC-1:0]      drop_s;
    logic [DATA_WIDTH-1:0] head_s [N_SRC];

    arb_state_t            state_r;
    logic                  wr_req_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [LG_W-1:0]       last_grant_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic [N_SRC-1:0]      overflow_r;
    logic [CNT_WIDTH-1:0]  drop_count_r;

    logic                  grant_found_s;
    logic [LG_W-1:0]       grant_idx_s;
    logic                  grant_slot_s;
    logic                  grant_en_s;
    int                    scan_idx_s;
    logic [CNT_WIDTH-1:0]  drop_base_s;
    logic [SUM_W-1:0]      drop_sum_s;
    logic [CNT_WIDTH-1:0]  drop_next_s;
    logic [N_SRC-1:0]      overflow_next_s;

    for (genvar g = 0; g < N_SRC; g++) begin : g_queue
        result_src_queue #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_queue (
            .clock (clock),
            .reset (reset),
            .push  (src_wr_req[g]),
            .pop   (pop_s[g]),
            .din   (src_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (head_s[g]),
            .empty (empty_s[g]),
            .full  (full_s[g])
        );
    end

    assign drop_s = src_wr_req & full_s & ~pop_s;

    // Round-robin pick: first non-empty queue after the last one written.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            scan_idx_s = (int'(last_grant_r) + k) % N_SRC;
            if (!grant_found_s && !empty_s[scan_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = LG_W'(scan_idx_s);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // The last GAP cycle doubles as IDLE so exactly GAP idle cycles separate writes.
    always_comb begin
        case (state_r)
            IDLE:                 grant_slot_s = 1'b1;
            WRITE:                grant_slot_s = (GAP == 0);
            pulse_ctrl_pkg::GAP:  grant_slot_s = (gap_cnt_r == '0);
            default:              grant_slot_s = 1'b0;
        endcase
        grant_en_s = grant_slot_s && grant_found_s && !rFIFO_full;
        for (int i = 0; i < N_SRC; i++) begin
            pop_s[i] = grant_en_s && (grant_idx_s == LG_W'(i));
        end
    end

    // Drop accounting: a drop in the clearing cycle survives the clear.
    always_comb begin
        drop_base_s     = clear_overflow ? '0 : drop_count_r;
        overflow_next_s = clear_overflow ? drop_s : (overflow_r | drop_s);
        drop_sum_s      = SUM_W'(drop_base_s) + SUM_W'(count_ones(32'(drop_s)));
        if (drop_sum_s > SUM_W'({CNT_WIDTH{1'b1}})) begin
            drop_next_s = '1;
        end else begin
            drop_next_s = drop_sum_s[CNT_WIDTH-1:0];
        end
    end

    // Arbiter FSM with registered write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            wr_req_r     <= 1'b0;
            data_r       <= '0;
            last_grant_r <= LG_W'(N_SRC - 1);
            gap_cnt_r    <= '0;
        end else if (grant_en_s) begin
            state_r      <= WRITE;
            wr_req_r     <= 1'b1;
            data_r       <= head_s[grant_idx_s];
            last_grant_r <= grant_idx_s;
            gap_cnt_r    <= '0;
        end else begin
            wr_req_r <= 1'b0;
            data_r   <= '0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                WRITE: begin
                    if (GAP > 0) begin
                        state_r   <= pulse_ctrl_pkg::GAP;
                        gap_cnt_r <= GAP_W'(GAP - 1);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                pulse_ctrl_pkg::GAP: begin
                    if (gap_cnt_r == '0) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flags and saturating drop counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_r   <= '0;
            drop_count_r <= '0;
        end else begin
            overflow_r   <= overflow_next_s;
            drop_count_r <= drop_next_s;
        end
    end

    assign rFIFO_WrReq  = wr_req_r;
    assign rFIFO_data   = data_r;
    assign src_overflow = overflow_r;
    assign drop_count   = drop_count_r;
    assign last_grant   = last_grant_r;
    assign pending      = (~empty_s != '0) || (state_r != IDLE);

endmodule

// File: tb/tb_result_write_arbiter.sv
// Scoreboard bench for result_write_arbiter: expected words are queued per
// source on push and matched against each rFIFO write.
module tb_result_write_arbiter;

    localparam int N_SRC = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int CNT_W = 16;

    typedef struct {
        int          src;
        logic [31:0] data;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [95:0]     src_data = '0;
    logic [2:0]      src_wr_req = '0;
    logic            rFIFO_full = 1'b0;
    logic            clear_overflow = 1'b0;
    logic [31:0]     rFIFO_data;
    logic            rFIFO_WrReq;
    logic [2:0]      src_overflow;
    logic [15:0]     drop_count;
    logic            pending;
    logic [1:0]      last_grant;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   write_count  = 0;
    exp_t exp_q[$];
    int   grant_log[$];

    result_write_arbiter #(
        .N_SRC(N_SRC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(GAP), .CNT_WIDTH(CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .src_data       (src_data),
        .src_wr_req     (src_wr_req),
        .rFIFO_full     (rFIFO_full),
        .clear_overflow (clear_overflow),
        .rFIFO_data     (rFIFO_data),
        .rFIFO_WrReq    (rFIFO_WrReq),
        .src_overflow   (src_overflow),
        .drop_count     (drop_count),
        .pending        (pending),
        .last_grant     (last_grant)
    );

    always #5 clock = ~clock;

    task automatic check_equal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one push cycle at the next falling edge and record accepted words.
    task automatic push_cycle(input logic [2:0] mask, input logic [95:0] data, input logic [2:0] accept);
        @(negedge clock);
        src_wr_req = mask;
        src_data   = data;
        for (int s = 0; s < 3; s++) begin
            if (accept[s]) exp_q.push_back('{s, data[s*32 +: 32]});
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        src_wr_req     = '0;
        src_data       = '0;
        rFIFO_full     = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        grant_log.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            #1;
            if (!pending && exp_q.size() == 0) done = 1'b1;
        end
        check_equal({tag, "_drained"}, 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] pack_log(input int start, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (start + i < grant_log.size()) r = {r[27:0], 4'(grant_log[start + i])};
            else r = {r[27:0], 4'hF};
        end
        return r;
    endfunction

    // Write monitor: each pulse must match the oldest outstanding word of its source.
    always @(negedge clock) begin
        if (!reset && rFIFO_WrReq) begin
            int src;
            int idx;
            src = int'(last_grant);
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (idx < 0 && exp_q[i].src == src) idx = i;
            end
            write_count++;
            grant_log.push_back(src);
            check_equal("write_expected", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
                check_equal("write_data", 64'(rFIFO_data), 64'(exp_q[idx].data));
                exp_q.delete(idx);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [2:0] mask;
        int   wc0;
        int   pos1;
        bit   sent1;
        bit   seen;
        int   cnt0;
        int   cnt2;

        // Reset state and single-word latency
        apply_reset();
        #1;
        check_equal("rst_wrreq", 64'(rFIFO_WrReq), 64'd0);
        check_equal("rst_data", 64'(rFIFO_data), 64'd0);
        check_equal("rst_overflow", 64'(src_overflow), 64'd0);
        check_equal("rst_drop", 64'(drop_count), 64'd0);
        check_equal("rst_pending", 64'(pending), 64'd0);
        check_equal("rst_last_grant", 64'(last_grant), 64'd2);
        push_cycle(3'b001, {64'h0, 32'hDEADBEEF}, 3'b001);
        @(posedge clock); #1;
        check_equal("t1_e0_wrreq", 64'(rFIFO_WrReq), 64'd0);
        check_equal("t1_e0_pending", 64'(pending), 64'd1);
        @(negedge clock); src_wr_req = '0;
        @(posedge clock); #1;
        check_equal("t1_e1_wrreq", 64'(rFIFO_WrReq), 64'd1);
        check_equal("t1_e1_data", 64'(rFIFO_data), 64'hDEADBEEF);
        check_equal("t1_e1_last_grant", 64'(last_grant), 64'd0);
        @(posedge clock); #1;
        check_equal("t1_e2_wrreq", 64'(rFIFO_WrReq), 64'd0);
        check_equal("t1_e2_data", 64'(rFIFO_data), 64'd0);
        wait_drain("t1", 20);

        // Simultaneous push from all sources, GAP spacing
        apply_reset();
        push_cycle(3'b111, {32'h3, 32'h2, 32'h1}, 3'b111);
        @(posedge clock);
        @(negedge clock); src_wr_req = '0;
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            pat[7-k] = rFIFO_WrReq;
        end
        check_equal("t2_pulse_pattern", 64'(pat), 64'hA8);
        wait_drain("t2", 20);
        check_equal("t2_grant_order", 64'(pack_log(0, 3)), 64'h012);
        check_equal("t2_overflow", 64'(src_overflow), 64'd0);

        // Backpressure with overflow on DDS
        @(negedge clock); rFIFO_full = 1'b1;
        wc0 = write_count;
        for (int i = 0; i < 6; i++) begin
            push_cycle(3'b001, {64'h0, 32'h3000_0000 + 32'(i)}, (i < 4) ? 3'b001 : 3'b000);
        end
        @(negedge clock); src_wr_req = '0;
        repeat (4) @(negedge clock);
        #1;
        check_equal("t3_overflow", 64'(src_overflow), 64'b001);
        check_equal("t3_drop", 64'(drop_count), 64'd2);
        check_equal("t3_no_write_while_full", 64'(write_count - wc0), 64'd0);
        check_equal("t3_pending", 64'(pending), 64'd1);
        @(negedge clock); rFIFO_full = 1'b0;
        wait_drain("t3", 40);
        check_equal("t3_write_count", 64'(write_count - wc0), 64'd4);
        @(negedge clock); clear_overflow = 1'b1;
        @(negedge clock); clear_overflow = 1'b0;
        #1;
        check_equal("t3_clear_overflow", 64'(src_overflow), 64'd0);
        check_equal("t3_clear_drop", 64'(drop_count), 64'd0);

        // Drop counter saturation and clear-vs-drop priority
        @(negedge clock); rFIFO_full = 1'b1;
        for (int r = 0; r < 4; r++) begin
            push_cycle(3'b111, {32'h5000_0200 | 32'(r), 32'h5000_0100 | 32'(r), 32'h5000_0000 | 32'(r)}, 3'b111);
        end
        #1;
        check_equal("t4_last_grant", 64'(last_grant), 64'd0);
        @(negedge clock); src_wr_req = 3'b111;
        repeat (23400) @(negedge clock);
        src_wr_req = '0;
        #1;
        check_equal("t4_drop_saturated", 64'(drop_count), 64'hFFFF);
        check_equal("t4_overflow_all", 64'(src_overflow), 64'b111);
        @(negedge clock); src_wr_req = 3'b001; clear_overflow = 1'b1;
        @(negedge clock); src_wr_req = '0; clear_overflow = 1'b0;
        #1;
        check_equal("t4_drop_after_clear", 64'(drop_count), 64'd1);
        check_equal("t4_overflow_after_clear", 64'(src_overflow), 64'b001);
        grant_log.delete();
        @(negedge clock); rFIFO_full = 1'b0;
        wait_drain("t4", 100);
        check_equal("t4_rr_order", 64'(pack_log(0, 6)), 64'h120120);

        // Fairness with sources 0 and 2 kept busy, one SPI push
        apply_reset();
        @(negedge clock); rFIFO_full = 1'b1;
        for (int r = 0; r < 4; r++) begin
            push_cycle(3'b101, {32'h7200_0000 | 32'(r), 32'h0, 32'h7000_0000 | 32'(r)}, 3'b101);
        end
        @(negedge clock); src_wr_req = '0; rFIFO_full = 1'b0;
        cnt0 = 4; cnt2 = 4; sent1 = 1'b0; pos1 = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clock); #1;
            mask = '0;
            if (c % 5 == 4) mask = mask | 3'b101;
            if (!sent1 && grant_log.size() >= 4) begin
                mask  = mask | 3'b010;
                sent1 = 1'b1;
                pos1  = grant_log.size();
            end
            src_wr_req = mask;
            src_data   = {32'h7200_0000 | 32'(cnt2), 32'h7100_0001, 32'h7000_0000 | 32'(cnt0)};
            for (int s = 0; s < 3; s++) begin
                if (mask[s]) exp_q.push_back('{s, src_data[s*32 +: 32]});
            end
            if (mask[0]) cnt0++;
            if (mask[2]) cnt2++;
        end
        @(negedge clock); src_wr_req = '0;
        wait_drain("t5", 300);
        check_equal("t5_alternate", 64'(pack_log(0, 4)), 64'h0202);
        check_equal("t5_spi_sent", 64'(sent1), 64'd1);
        check_equal("t5_spi_within_2", 64'(pack_log(pos1, 1) == 32'h1 || pack_log(pos1 + 1, 1) == 32'h1), 64'd1);
        check_equal("t5_overflow", 64'(src_overflow), 64'd0);

        // Reset during a write with words still queued
        apply_reset();
        @(negedge clock); rFIFO_full = 1'b1;
        for (int r = 0; r < 4; r++) begin
            push_cycle(3'b001, {64'h0, 32'h9000_0000 | 32'(r)}, 3'b001);
        end
        @(negedge clock); src_wr_req = '0; rFIFO_full = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock); #1;
            if (rFIFO_WrReq) seen = 1'b1;
        end
        check_equal("t6_write_started", 64'(seen), 64'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check_equal("t6_rst_wrreq", 64'(rFIFO_WrReq), 64'd0);
        check_equal("t6_rst_data", 64'(rFIFO_data), 64'd0);
        check_equal("t6_rst_pending", 64'(pending), 64'd0);
        check_equal("t6_rst_last_grant", 64'(last_grant), 64'd2);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wc0 = write_count;
        repeat (15) @(negedge clock);
        #1;
        check_equal("t6_no_stale_write", 64'(write_count - wc0), 64'd0);
        check_equal("t6_pending_after", 64'(pending), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
